// File: rtl/sipo_deserializer_if.sv
// Bundle of the serial receive stream and the word-level valid/ready side of the deserializer.
// The master side feeds bits and consumes words; the slave side is the deserializer itself.
interface sipo_deserializer_if #(
   parameter int WIDTH = 8
);
   logic             serial_in;
   logic             bit_valid;
   logic             start;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             data_ready;
   logic             overflow;
   logic             clear_ovf;
   logic             frame_err;
   logic             busy;

   modport master (
      output serial_in, bit_valid, start, data_ready, clear_ovf,
      input  data_out, data_valid, overflow, frame_err, busy
   );

   modport slave (
      input  serial_in, bit_valid, start, data_ready, clear_ovf,
      output data_out, data_valid, overflow, frame_err, busy
   );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: start-aligned bit assembly into WIDTH-bit words,
// feeding a 2-entry valid/ready buffer with sticky overflow and resync frame errors.
module sipo_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                clk,
   input logic                rst,
   sipo_deserializer_if.slave bus
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] sreg, sreg_nxt;
   logic [WIDTH-1:0] word_in;
   logic             push;
   logic             frame_err_q, frame_err_nxt;

   // Bit #0 always ends up at WIDTH-1 (MSB-first) or 0 (LSB-first) after WIDTH shifts.
   function automatic logic [WIDTH-1:0] first_bit(input logic b);
      return MSB_FIRST ? {{(WIDTH-1){1'b0}}, b} : {b, {(WIDTH-1){1'b0}}};
   endfunction

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
      return MSB_FIRST ? {cur[WIDTH-2:0], b} : {b, cur[WIDTH-1:1]};
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      sreg_nxt      = sreg;
      push          = 1'b0;
      frame_err_nxt = 1'b0;
      word_in       = shift_in(sreg, bus.serial_in);

      if (bus.bit_valid) begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  sreg_nxt  = first_bit(bus.serial_in);
                  cnt_nxt   = CW'(1);
                  state_nxt = SHIFT;
               end
            end
            SHIFT: begin
               if (bus.start) begin
                  frame_err_nxt = 1'b1;
                  sreg_nxt      = first_bit(bus.serial_in);
                  cnt_nxt       = CW'(1);
               end else if (cnt == LAST) begin
                  push      = 1'b1;
                  sreg_nxt  = word_in;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  sreg_nxt = word_in;
                  cnt_nxt  = cnt + CW'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         sreg        <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         sreg        <= sreg_nxt;
         frame_err_q <= frame_err_nxt;
      end
   end

   logic [WIDTH-1:0] mem [2];
   logic             rd_ptr, wr_ptr;
   logic [1:0]       count;
   logic             pop, full, push_ok, drop;
   logic             overflow_q;

   assign pop     = (count != 2'd0) && bus.data_ready;
   assign full    = (count == 2'd2);
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   // When full with a pop, wr_ptr equals rd_ptr, so the new word overwrites the slot being vacated.
   // NOTE: the two storage words are reset because data_out must read 0 out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= word_in;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case ({push_ok, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // A drop on the same edge as clear_ovf keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (bus.clear_ovf) begin
         overflow_q <= 1'b0;
      end
   end

   assign bus.data_out   = mem[rd_ptr];
   assign bus.data_valid = (count != 2'd0);
   assign bus.overflow   = overflow_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = (state == SHIFT);

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-to-parallel receive stage that consumes the MSB-first bit stream produced by the team's 8-bit parallel-in/serial-out shift register and reassembles whole words. Incoming bits are qualified by a bit strobe and aligned by a start marker. Completed words go into a 2-entry output buffer with a valid/ready handshake. Overflow and framing errors are flagged so the downstream consumer can detect lost data.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32
- MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- serial_in  input  1  serial data bit
- bit_valid  input  1  serial_in is sampled on this edge when 1
- start  input  1  qualified by bit_valid; marks the current bit as the first bit of a word
- data_out  output  WIDTH  head-of-buffer word
- data_valid  output  1  buffer non-empty; data_out is meaningful
- data_ready  input  1  consumer accepts the head word when data_valid && data_ready
- overflow  output  1  sticky; a completed word was dropped because the buffer was full
- clear_ovf  input  1  synchronous clear of overflow
- frame_err  output  1  one-cycle pulse; a partial word was discarded by resync
- busy  output  1  a word is partially assembled (FSM in SHIFT)

## Operation
- FSM states:
  - IDLE: no partial word.
  - SHIFT: collecting bits; bit counter cnt runs 0..WIDTH-1.
- In IDLE:
  - bit_valid && start: load the bit as word bit #0 (MSB when MSB_FIRST=1), set cnt=1, go to SHIFT.
  - bit_valid && !start: ignore the bit and stay in IDLE (no frame_err).
- In SHIFT, bit_valid && !start: shift the bit in and increment cnt.
  - Completion occurs on the edge that accepts the bit when cnt==WIDTH-1.
  - At completion: push the assembled word into the buffer and go to IDLE.
- In SHIFT, bit_valid && start: resync.
  - Discard the partial word and pulse frame_err for one cycle.
  - The current bit becomes bit #0 of a new word; cnt=1; stay in SHIFT.
- bit_valid=0: no state, counter or shift change in any state.
- Output buffer: 2-entry FIFO; data_out always shows the oldest entry.
- Pop: data_valid && data_ready.
- Push when the buffer holds 2 entries:
  - Push with a pop on the same edge: accepted; occupancy stays 2.
  - Push without a pop: the new word is dropped, overflow is set, and buffer contents are unchanged.
- clear_ovf clears overflow. clear_ovf on the same edge as a new drop: overflow stays 1 (set wins).
- The consumer must hold data_ready independent of data_valid; no combinational path from data_ready to data_valid.

## Timing
- Reset (rst=0): asynchronously forces IDLE, cnt=0, buffer empty, data_out=0, data_valid=0, overflow=0, frame_err=0, busy=0.
- Reset mid-word: the partial word is lost and no frame_err is raised.
- Latency: a word completed on edge N has data_valid=1 and data_out valid after edge N.
  - Buffer empty at edge N: the word is at the head immediately.
- Back-to-back words with no gap: start may arrive on the edge directly after completion.
  - The FSM is in IDLE at that edge and accepts it.
- Throughput: one bit per clock; one word per WIDTH clocks sustained with data_ready=1.
- busy=1 exactly while the state is SHIFT; frame_err is registered.
- data_out is registered from FIFO storage and is stable while data_valid=1 and no pop occurs.

## Test plan
- Reset then word: rst low→high; send 0xA5 MSB-first with start on the first bit and data_ready=1.
  - Required: data_valid=1 with data_out=0xA5 one edge after the 8th bit, then data_valid=0 after the pop.
- Back-to-back: send 0x3C, 0xC3, 0xFF with no idle cycles and data_ready=1.
  - Required: three consecutive pops of 0x3C, 0xC3, 0xFF; overflow=0; frame_err never pulses.
- Overflow: hold data_ready=0 and send 0x11, 0x22, 0x33.
  - Required: buffer holds 0x11, 0x22 and overflow=1 after the 3rd word.
  - Then raise data_ready: pops 0x11 then 0x22.
  - Pulse clear_ovf: overflow=0.
- Resync: send 3 bits, then assert start with 0x81.
  - Required: frame_err pulses once and the delivered word is 0x81.
  - Leading bits with start=0 while in IDLE are ignored.
- Gapped strobe and async reset: send 0x5A with bit_valid low for 2 cycles between bits.
  - Required: 0x5A is delivered.
  - Next word: drive rst=0 after 4 bits. Required: all outputs go to reset values immediately, and the following word 0x0F is received correctly.
- MSB_FIRST=0: send bits 1,0,0,0,0,0,0,0.
  - Required: data_out=0x01.
  - Full-while-popping: with 2 entries buffered, a completion coinciding with a pop is accepted with no overflow.
